// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and encodings shared by the fetch stage, IF/ID and control.
//   PC_WIDTH     width of PC and instruction-memory address
//   NO_OP        bubble instruction inserted on squash/stall/halt
//   HALT_OPCODE  opcode (instr[31:26]) that stops fetch
//   fetch_state_e  fetch FSM encoding, pc_sel_e  next-PC mux select
package cpu_pkg;
    localparam int          PC_WIDTH    = 32;
    localparam logic [31:0] NO_OP       = 32'hF000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {FETCH, STALL, REDIR, HALT} fetch_state_e;
    typedef enum logic [1:0] {PC_SEL_RESET, PC_SEL_TARGET, PC_SEL_HOLD, PC_SEL_INC} pc_sel_e;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[31:26] == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: bundles the fetch stage's control, imem and IF/ID signals.
//   data_hazard, branch_taken, branch_target  control inputs to fetch
//   imem_data (in), imem_addr/imem_rd_en (out) synchronous-read instruction memory
//   instruction_out, PC_out, flush_out        to the IF/ID register
//   halted                                    fetch stopped on HALT
//   master: the fetch stage; slave: its environment
interface instr_fetch_stage_if;
    import cpu_pkg::*;
    logic                data_hazard;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic [31:0]         imem_data;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rd_en;
    logic [31:0]         instruction_out;
    logic [PC_WIDTH-1:0] PC_out;
    logic                flush_out;
    logic                halted;

    modport master (
        input  data_hazard, branch_taken, branch_target, imem_data,
        output imem_addr, imem_rd_en, instruction_out, PC_out, flush_out, halted
    );
    modport slave (
        output data_hazard, branch_taken, branch_target, imem_data,
        input  imem_addr, imem_rd_en, instruction_out, PC_out, flush_out, halted
    );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux.
//   sel     which source to take (reset / target / hold / increment)
//   pc_q    current PC, target redirect address
//   pc_d    next PC; increment wraps modulo 2^PC_WIDTH
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 1
) (
    input  pc_sel_e             sel,
    input  logic [PC_WIDTH-1:0] pc_q,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc_d
);
    always_comb
        pc_d = sel == PC_SEL_TARGET ? target :
               sel == PC_SEL_HOLD   ? pc_q   :
               sel == PC_SEL_INC    ? pc_q + PC_STEP : RESET_PC;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: owns the PC, drives a 1-cycle synchronous imem and feeds IF/ID.
//   clk, rst  clock and asynchronous active-high reset
//   bus       instr_fetch_stage_if.master: hazard/redirect inputs, imem port,
//             instruction_out/PC_out/flush_out to IF/ID, halted status
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 1
) (
    input logic                  clk,
    input logic                  rst,
    instr_fetch_stage_if.master  bus
);
    fetch_state_e        state_q, state_d;
    pc_sel_e             pc_sel;
    logic [PC_WIDTH-1:0] pc_q, pc_d, resp_pc_q, hold_pc_q, cur_pc;
    logic [31:0]         hold_instr_q, cur_instr;
    logic                resp_valid_q, hold_valid_q, hold_valid_d, cur_valid;
    logic                rd_en, capture;

    pc_next_sel #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_next (
        .sel    (pc_sel),
        .pc_q   (pc_q),
        .target (bus.branch_target),
        .pc_d   (pc_d)
    );

    // The instruction on offer to IF/ID: a held (stalled) one takes precedence
    // over a fresh imem response; the two are never valid together.
    always_comb begin
        cur_valid = hold_valid_q | resp_valid_q;
        cur_instr = hold_valid_q ? hold_instr_q : bus.imem_data;
        cur_pc    = hold_valid_q ? hold_pc_q : resp_pc_q;
    end

    always_comb begin
        state_d      = state_q;
        pc_sel       = PC_SEL_HOLD;
        rd_en        = 1'b0;
        capture      = 1'b0;
        hold_valid_d = 1'b0;
        if (bus.branch_taken) begin
            state_d = REDIR;
            pc_sel  = PC_SEL_TARGET;
        end else if (state_q == REDIR) begin
            // Fetch the target even under a hazard: nothing valid is on offer
            // yet, and a stalled response lands in the hold register next cycle.
            state_d = FETCH;
            pc_sel  = PC_SEL_INC;
            rd_en   = 1'b1;
        end else if (state_q != HALT && bus.data_hazard) begin
            state_d      = STALL;
            capture      = !hold_valid_q && resp_valid_q;
            hold_valid_d = cur_valid;
        end else if (state_q != HALT && !(cur_valid && is_halt(cur_instr))) begin
            state_d = FETCH;
            pc_sel  = PC_SEL_INC;
            rd_en   = 1'b1;
        end else begin
            // HALT is handed to IF/ID this cycle; no further reads are issued.
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NO_OP;
            hold_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= rd_en;
            hold_valid_q <= hold_valid_d;
            if (rd_en) resp_pc_q <= pc_q;
            if (capture) begin
                hold_instr_q <= bus.imem_data;
                hold_pc_q    <= resp_pc_q;
            end
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.imem_rd_en      = rd_en && !rst;
    assign bus.flush_out       = !rst && (bus.branch_taken || state_q == REDIR);
    assign bus.instruction_out = cur_valid && !bus.flush_out ? cur_instr : NO_OP;
    assign bus.PC_out          = cur_pc;
    assign bus.halted          = state_q == HALT;
endmodule
